// File: rtl/es_stack_unit_pkg.sv
// es_stack_unit_pkg: expression-stack opcodes and op classification helpers
package es_stack_unit_pkg;
  localparam logic [2:0] ES_NOP   = 3'd0;
  localparam logic [2:0] ES_PUSH  = 3'd1;
  localparam logic [2:0] ES_POP   = 3'd2;
  localparam logic [2:0] ES_REPL  = 3'd3;
  localparam logic [2:0] ES_SWAP  = 3'd4;
  localparam logic [2:0] ES_DUP   = 3'd5;
  localparam logic [2:0] ES_OVER  = 3'd6;
  localparam logic [2:0] ES_CLEAR = 3'd7;
  function automatic logic [1:0] es_need(input logic [2:0] op, input logic amt);
    return op == ES_POP ? (amt ? 2'd2 : 2'd1) :
           (op == ES_REPL || op == ES_SWAP || op == ES_OVER) ? 2'd2 :
           op == ES_DUP ? 2'd1 : 2'd0;
  endfunction
  function automatic logic es_grows(input logic [2:0] op);
    return op == ES_PUSH || op == ES_DUP || op == ES_OVER;
  endfunction
endpackage

// File: rtl/es_stack_unit_if.sv
// es_stack_unit_if: op request and stack status bundle for the expression stack
interface es_stack_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic              es_act;
  logic [2:0]        es_op;
  logic              pop_amt;
  logic [DATA_W-1:0] push_val;
  logic              err_clr;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [CNT_W-1:0]  depth;
  logic              empty;
  logic              full;
  logic              ovf_err;
  logic              unf_err;
  modport master (
    output es_act, es_op, pop_amt, push_val, err_clr,
    input  a_val, b_val, depth, empty, full, ovf_err, unf_err
  );
  modport slave (
    input  es_act, es_op, pop_amt, push_val, err_clr,
    output a_val, b_val, depth, empty, full, ovf_err, unf_err
  );
endinterface

// File: rtl/es_stack_unit_spill_mem.sv
// es_stack_unit_spill_mem: flop array below TOS/NOS, one write port, two async read ports
module es_stack_unit_spill_mem #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int N      = DEPTH - 2,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/es_stack_unit.sv
// es_stack_unit: LIFO expression stack with registered TOS/NOS, depth tracking and sticky error flags
module es_stack_unit
  import es_stack_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input logic           clk,
  input logic           reset,
  es_stack_unit_if.slave s
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int N     = DEPTH - 2;
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  logic [CNT_W-1:0]  d, d_nxt, sp;
  logic [DATA_W-1:0] tos, nos, tos_nxt, nos_nxt, rd1, rd2;
  logic              unf, ovf, ok, we, deep1, deep2, ovf_q, unf_q;
  // sp counts spilled words; the array top sits at sp-1
  assign sp    = d >= CNT_W'(2) ? d - CNT_W'(2) : '0;
  assign deep1 = d >= CNT_W'(3);
  assign deep2 = d >= CNT_W'(4);
  es_stack_unit_spill_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(we),
    .wa(AW'(sp)),
    .wd(nos),
    .ra1(AW'(sp - CNT_W'(1))),
    .ra2(AW'(sp - CNT_W'(2))),
    .rd1(rd1),
    .rd2(rd2)
  );
  always_comb begin
    unf     = s.es_act && d < CNT_W'(es_need(s.es_op, s.pop_amt));
    ovf     = s.es_act && !unf && es_grows(s.es_op) && d == CNT_W'(DEPTH);
    ok      = s.es_act && !unf && !ovf;
    we      = ok && es_grows(s.es_op) && d >= CNT_W'(2);
    d_nxt   = d;
    tos_nxt = tos;
    nos_nxt = nos;
    if (ok)
      case (s.es_op)
        ES_PUSH:  begin d_nxt = d + CNT_W'(1); tos_nxt = s.push_val; nos_nxt = tos; end
        ES_POP:   begin
          d_nxt   = s.pop_amt ? d - CNT_W'(2) : d - CNT_W'(1);
          tos_nxt = !s.pop_amt ? nos : deep1 ? rd1 : '0;
          nos_nxt = !s.pop_amt ? (deep1 ? rd1 : '0) : deep2 ? rd2 : '0;
        end
        ES_REPL:  begin d_nxt = d - CNT_W'(1); tos_nxt = s.push_val; nos_nxt = deep1 ? rd1 : '0; end
        ES_SWAP:  begin tos_nxt = nos; nos_nxt = tos; end
        ES_DUP:   begin d_nxt = d + CNT_W'(1); nos_nxt = tos; end
        ES_OVER:  begin d_nxt = d + CNT_W'(1); tos_nxt = nos; nos_nxt = tos; end
        ES_CLEAR: begin d_nxt = '0; tos_nxt = '0; nos_nxt = '0; end
        default:  ;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d     <= '0;
      tos   <= '0;
      nos   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      d     <= d_nxt;
      tos   <= tos_nxt;
      nos   <= nos_nxt;
      ovf_q <= ovf || (ovf_q && !s.err_clr);
      unf_q <= unf || (unf_q && !s.err_clr);
    end
  assign s.a_val   = tos;
  assign s.b_val   = nos;
  assign s.depth   = d;
  assign s.empty   = d == '0;
  assign s.full    = d == CNT_W'(DEPTH);
  assign s.ovf_err = ovf_q;
  assign s.unf_err = unf_q;
endmodule

// File: tb/tb_es_stack_unit.sv
// tb_es_stack_unit: directed and random ops against a queue model of the expression stack
module tb_es_stack_unit;
  import es_stack_unit_pkg::*;
  localparam int DW = 16;
  localparam int DP = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;
  logic [DW-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  es_stack_unit_if #(.DATA_W(DW), .DEPTH(DP)) ifc ();
  es_stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (.clk(clk), .reset(reset), .s(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_a();
    return q.size() > 0 ? 32'(q[$]) : 32'd0;
  endfunction

  function automatic logic [31:0] m_b();
    return q.size() > 1 ? 32'(q[$-1]) : 32'd0;
  endfunction

  task automatic apply();
    int d = q.size();
    bit o = 1'b0;
    bit u = 1'b0;
    logic [DW-1:0] t, n;
    if (ifc.es_act)
      case (ifc.es_op)
        ES_PUSH:  if (d == DP) o = 1'b1; else q.push_back(ifc.push_val);
        ES_POP:   if (d < (ifc.pop_amt ? 2 : 1)) u = 1'b1; else repeat (ifc.pop_amt ? 2 : 1) void'(q.pop_back());
        ES_REPL:  if (d < 2) u = 1'b1; else begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(ifc.push_val); end
        ES_SWAP:  if (d < 2) u = 1'b1; else begin t = q.pop_back(); n = q.pop_back(); q.push_back(t); q.push_back(n); end
        ES_DUP:   if (d < 1) u = 1'b1; else if (d == DP) o = 1'b1; else q.push_back(q[$]);
        ES_OVER:  if (d < 2) u = 1'b1; else if (d == DP) o = 1'b1; else q.push_back(q[$-1]);
        ES_CLEAR: q.delete();
        default:  ;
      endcase
    m_ovf = o || (m_ovf && !ifc.err_clr);
    m_unf = u || (m_unf && !ifc.err_clr);
  endtask

  task automatic step(input logic a, input logic [2:0] op, input logic amt, input logic [DW-1:0] v, input logic clr);
    ifc.es_act = a;
    ifc.es_op = op;
    ifc.pop_amt = amt;
    ifc.push_val = v;
    ifc.err_clr = clr;
    @(posedge clk);
    if (reset) apply();
    #1;
  endtask

  always @(negedge clk)
    if (run && reset) begin
      chk("a_val", 32'(ifc.a_val), m_a());
      chk("b_val", 32'(ifc.b_val), m_b());
      chk("depth", 32'(ifc.depth), 32'(q.size()));
      chk("empty", 32'(ifc.empty), 32'(q.size() == 0));
      chk("full", 32'(ifc.full), 32'(q.size() == DP));
      chk("ovf_err", 32'(ifc.ovf_err), 32'(m_ovf));
      chk("unf_err", 32'(ifc.unf_err), 32'(m_unf));
    end

  initial begin
    ifc.es_act = 1'b0;
    ifc.es_op = ES_NOP;
    ifc.pop_amt = 1'b0;
    ifc.push_val = '0;
    ifc.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run = 1'b1;
    // test 1: reset pulled low while a PUSH is being presented
    step(1'b1, ES_PUSH, 1'b0, 16'h1234, 1'b0);
    chk("t1_pre_depth", 32'(ifc.depth), 1);
    ifc.push_val = 16'h5555;
    #3 reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1 ifc.es_act = 1'b0;
    #2 reset = 1'b1;
    chk("t1_depth", 32'(ifc.depth), 0);
    chk("t1_a", 32'(ifc.a_val), 0);
    chk("t1_b", 32'(ifc.b_val), 0);
    chk("t1_empty", 32'(ifc.empty), 1);
    chk("t1_ovf", 32'(ifc.ovf_err), 0);
    chk("t1_unf", 32'(ifc.unf_err), 0);
    // test 2: fill to DEPTH, then overflow
    for (int i = 1; i <= 8; i++) step(1'b1, ES_PUSH, 1'b0, 16'(i), 1'b0);
    chk("t2_full", 32'(ifc.full), 1);
    chk("t2_a", 32'(ifc.a_val), 'h8);
    chk("t2_b", 32'(ifc.b_val), 'h7);
    chk("t2_model_a", m_a(), 'h8);
    step(1'b1, ES_PUSH, 1'b0, 16'h0009, 1'b0);
    chk("t2_ovf", 32'(ifc.ovf_err), 1);
    chk("t2_ovf_depth", 32'(ifc.depth), 8);
    chk("t2_ovf_a", 32'(ifc.a_val), 'h8);
    // test 3: pops refill from the array, REPL
    step(1'b1, ES_POP, 1'b0, 16'h0, 1'b0);
    chk("t3_pop1_a", 32'(ifc.a_val), 'h7);
    step(1'b1, ES_POP, 1'b0, 16'h0, 1'b0);
    chk("t3_pop2_a", 32'(ifc.a_val), 'h6);
    chk("t3_pop2_b", 32'(ifc.b_val), 'h5);
    step(1'b1, ES_REPL, 1'b0, 16'hABCD, 1'b0);
    chk("t3_repl_a", 32'(ifc.a_val), 'hABCD);
    chk("t3_repl_b", 32'(ifc.b_val), 'h4);
    chk("t3_repl_depth", 32'(ifc.depth), 5);
    chk("t3_model_b", m_b(), 'h4);
    // test 4: SWAP, OVER, DUP
    step(1'b1, ES_CLEAR, 1'b0, 16'h0, 1'b1);
    step(1'b1, ES_PUSH, 1'b0, 16'h1111, 1'b0);
    step(1'b1, ES_PUSH, 1'b0, 16'h2222, 1'b0);
    step(1'b1, ES_SWAP, 1'b0, 16'h0, 1'b0);
    chk("t4_swap_a", 32'(ifc.a_val), 'h1111);
    chk("t4_swap_b", 32'(ifc.b_val), 'h2222);
    step(1'b1, ES_OVER, 1'b0, 16'h0, 1'b0);
    chk("t4_over_a", 32'(ifc.a_val), 'h2222);
    chk("t4_over_depth", 32'(ifc.depth), 3);
    step(1'b1, ES_DUP, 1'b0, 16'h0, 1'b0);
    chk("t4_dup_a", 32'(ifc.a_val), 'h2222);
    chk("t4_dup_b", 32'(ifc.b_val), 'h2222);
    chk("t4_dup_depth", 32'(ifc.depth), 4);
    // test 5: underflow and sticky flag clearing
    step(1'b1, ES_CLEAR, 1'b0, 16'h0, 1'b0);
    step(1'b1, ES_PUSH, 1'b0, 16'h0077, 1'b0);
    step(1'b1, ES_POP, 1'b0, 16'h0, 1'b0);
    chk("t5_empty", 32'(ifc.empty), 1);
    chk("t5_a", 32'(ifc.a_val), 0);
    step(1'b1, ES_POP, 1'b0, 16'h0, 1'b0);
    chk("t5_unf", 32'(ifc.unf_err), 1);
    chk("t5_depth", 32'(ifc.depth), 0);
    step(1'b1, ES_SWAP, 1'b0, 16'h0, 1'b1);
    chk("t5_set_wins", 32'(ifc.unf_err), 1);
    step(1'b0, ES_NOP, 1'b0, 16'h0, 1'b1);
    chk("t5_clr", 32'(ifc.unf_err), 0);
    chk("t5_model_unf", 32'(m_unf), 0);
    // test 6: random ops, checked every cycle by the compare process
    for (int i = 0; i < 2000; i++) begin
      int r = $urandom_range(0, 31);
      step($urandom_range(0, 9) != 0, r == 0 ? ES_CLEAR : 3'(r % 7),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
           $urandom_range(0, 19) == 0);
    end
    step(1'b0, ES_NOP, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
